instr_decoder: RTL and testbench
================================

INSTR_DECODER -- requirements
Module: instr_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: clk cycles allowed between command byte and data byte (used only with INSTR_DECODER_TIMEOUT_EN).
REQ-002 clk  input  1  peripheral clock; all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 byte_sync  input  1  one-clk pulse from spi_bridge: new byte valid on data_in.
REQ-005 data_in  input  8  received SPI byte.
REQ-006 data_out  output  8  byte spi_bridge shifts out during the next SPI byte.
REQ-007 read  output  1  one-clk register-read strobe.
REQ-008 write  output  1  one-clk register-write strobe.
REQ-009 addr  output  6  register address.
REQ-010 hl_sel  output  1  byte select of 16-bit register: 1=high [15:8], 0=low [7:0].
REQ-011 data_read  input  8  register read data, valid the cycle after read.
REQ-012 data_write  output  8  register write data, valid while write=1.
REQ-013 timeout  output  1  one-clk pulse on aborted transaction (tied 0 without the macro).

Function
REQ-014 Transaction = 2 bytes: command byte, then data byte.
REQ-015 Command byte: bit7 = 1 write / 0 read; bit6 = hl_sel; bits5:0 = addr.
REQ-016 States: IDLE, WAIT_DATA, READ_CAPTURE; reset state IDLE.
REQ-017 IDLE + byte_sync: latch rw, hl_sel, addr; write -> WAIT_DATA; read -> READ_CAPTURE with read=1 in the next cycle.
REQ-018 READ_CAPTURE: single cycle; load data_out <= data_read; -> WAIT_DATA.
REQ-019 WAIT_DATA + byte_sync, write: data_write <= data_in; write=1 exactly one cycle later; -> IDLE.
REQ-020 WAIT_DATA + byte_sync, read: data byte ignored (dummy); -> IDLE; no strobe.
REQ-021 byte_sync during READ_CAPTURE: ignored; no state or output change.
REQ-022 read and write are never 1 in the same cycle; each is at most one cycle per transaction.
REQ-023 addr, hl_sel hold the latched value until the next command byte.
REQ-024 data_write holds until the next write; data_out holds until the next read capture.
REQ-025 Back-to-back transactions: byte_sync in the cycle after a return to IDLE is decoded as a new command.

Reset
REQ-026 rst_n low: state=IDLE; read=0, write=0, timeout=0, addr=0, hl_sel=0, data_write=0x00, data_out=0x00; timeout counter=0.
REQ-027 Reset mid-transaction: partial transaction is discarded; no strobe is issued after release.

Configuration
REQ-028 Macro INSTR_DECODER_TIMEOUT_EN defined: counter clears on entry to WAIT_DATA and increments each cycle in WAIT_DATA; at TIMEOUT_CYCLES without byte_sync -> IDLE and timeout pulses one cycle, no write/read side effect.
REQ-029 Macro undefined: no counter; WAIT_DATA waits indefinitely; timeout tied 0.
REQ-030 byte_sync in the same cycle the counter reaches TIMEOUT_CYCLES: byte accepted, no timeout.

Structure
REQ-031 Shared package pwmgen_pkg holds state encoding, command-bit positions (RW_BIT=7, HL_BIT=6, ADDR_MSB=5), and ADDR_W=6.
REQ-032 Single module; no sub-module (timeout counter inline under the macro).

Verification
REQ-033 Write: bytes 0x85, then 0xA5 -> write=1 one cycle, addr=0x05, hl_sel=0, data_write=0xA5; read stays 0.
REQ-034 Read: byte 0x4A, data_read=0x3C -> read=1 one cycle, addr=0x0A, hl_sel=1, data_out=0x3C before the second byte; dummy 0x00 -> IDLE, write stays 0.
REQ-035 Back-to-back: 0xC1,0x11,0x01,0xFF -> write (addr 1, hi, 0x11), then read addr 1; exactly one strobe each.
REQ-036 Reset mid-transaction: 0x83, then rst_n pulse, then 0x22 -> 0x22 decoded as command (read, addr 0x22), no write.
REQ-037 Timeout (macro on, TIMEOUT_CYCLES=16): 0x90, then idle for 16 cycles -> timeout=1 once, state IDLE, no write; the following byte is decoded as a command.

Source files
------------

// File: rtl/pwmgen_pkg.sv
// Shared definitions for the SPI instruction decoder: FSM encoding,
// command-byte bit positions and register address width.
package pwmgen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_DATA    = 2'd1,
    ST_READ_CAPTURE = 2'd2
  } state_t;

  localparam int RW_BIT   = 7;
  localparam int HL_BIT   = 6;
  localparam int ADDR_MSB = 5;
  localparam int ADDR_W   = 6;

endpackage

// File: rtl/instr_decoder.sv
// Two-byte SPI command decoder (command byte, then data byte) driving register
// read/write strobes. Optional data-byte timeout enabled by INSTR_DECODER_TIMEOUT_EN.
module instr_decoder
  import pwmgen_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_sync,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic              hl_sel,
  input  logic [7:0]        data_read,
  output logic [7:0]        data_write,
  output logic              timeout,
  output logic [1:0]        dbg_state
);

  // Handshake: byte_sync is a one-cycle valid with no back-pressure; read and
  // write are one-cycle strobes, never both high, at most one per transaction.
  state_t              state_q;
  logic                rw_q;
  logic                hl_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                read_q;
  logic                write_q;
  logic [7:0]          data_write_q;
  logic [7:0]          data_out_q;

`ifdef INSTR_DECODER_TIMEOUT_EN
  localparam int         CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]      cnt_q;
  logic                  timeout_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rw_q         <= 1'b0;
      hl_q         <= 1'b0;
      addr_q       <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      data_write_q <= 8'h00;
      data_out_q   <= 8'h00;
`ifdef INSTR_DECODER_TIMEOUT_EN
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
`ifdef INSTR_DECODER_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (byte_sync) begin
            rw_q   <= data_in[RW_BIT];
            hl_q   <= data_in[HL_BIT];
            addr_q <= data_in[ADDR_MSB:0];
            if (data_in[RW_BIT]) begin
              state_q <= ST_WAIT_DATA;
`ifdef INSTR_DECODER_TIMEOUT_EN
              cnt_q   <= '0;
`endif
            end else begin
              state_q <= ST_READ_CAPTURE;
              read_q  <= 1'b1;
            end
          end
        end

        // Any byte_sync arriving here is deliberately dropped.
        ST_READ_CAPTURE: begin
          data_out_q <= data_read;
          state_q    <= ST_WAIT_DATA;
`ifdef INSTR_DECODER_TIMEOUT_EN
          cnt_q      <= '0;
`endif
        end

        ST_WAIT_DATA: begin
          if (byte_sync) begin
            if (rw_q) begin
              data_write_q <= data_in;
              write_q      <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
`ifdef INSTR_DECODER_TIMEOUT_EN
          // A byte landing in the expiry cycle wins over the timeout.
          else if (cnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign read       = read_q;
  assign write      = write_q;
  assign addr       = addr_q;
  assign hl_sel     = hl_q;
  assign data_write = data_write_q;
  assign dbg_state  = state_q;

`ifdef INSTR_DECODER_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_instr_decoder.sv
// Directed bench for instr_decoder: write, read, back-to-back, mid-transaction
// reset and data-byte timeout (INSTR_DECODER_TIMEOUT_EN selects which timeout case).
module tb_instr_decoder;
  import pwmgen_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       byte_sync;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       read;
  logic       write;
  logic [5:0] addr;
  logic       hl_sel;
  logic [7:0] data_read;
  logic [7:0] data_write;
  logic       timeout;
  logic [1:0] dbg_state;

  int n_tests;
  int n_fail;
  int rd_cnt, wr_cnt, to_cnt, ovl_cnt;
  int rd0, wr0, to0;

  instr_decoder #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_sync  (byte_sync),
    .data_in    (data_in),
    .data_out   (data_out),
    .read       (read),
    .write      (write),
    .addr       (addr),
    .hl_sel     (hl_sel),
    .data_read  (data_read),
    .data_write (data_write),
    .timeout    (timeout),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strobe monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (read)          rd_cnt++;
    if (write)         wr_cnt++;
    if (timeout)       to_cnt++;
    if (read && write) ovl_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // caller is always aligned to a negedge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    data_in   = b;
    byte_sync = 1'b1;
    @(negedge clk);
    byte_sync = 1'b0;
  endtask

  task automatic snap();
    tick(1);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    to0 = to_cnt;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rd_cnt = 0; wr_cnt = 0; to_cnt = 0; ovl_cnt = 0;
    rst_n = 1'b0; byte_sync = 1'b0; data_in = 8'h00; data_read = 8'h00;
    tick(2);

    check("rst_state", dbg_state, ST_IDLE);
    check("rst_read", read, 0);
    check("rst_write", write, 0);
    check("rst_timeout", timeout, 0);
    check("rst_addr", addr, 0);
    check("rst_hl", hl_sel, 0);
    check("rst_dw", data_write, 8'h00);
    check("rst_do", data_out, 8'h00);
    rst_n = 1'b1;
    snap();

    // write: 0x85 then 0xA5
    send_byte(8'h85);
    check("wr_state_wait", dbg_state, ST_WAIT_DATA);
    check("wr_addr", addr, 6'h05);
    check("wr_hl", hl_sel, 0);
    send_byte(8'hA5);
    check("wr_strobe", write, 1);
    check("wr_data", data_write, 8'hA5);
    check("wr_state_idle", dbg_state, ST_IDLE);
    tick(1);
    check("wr_strobe_end", write, 0);
    tick(1);
    check("wr_nwr", wr_cnt - wr0, 1);
    check("wr_nrd", rd_cnt - rd0, 0);

    // read: 0x4A with data_read 0x3C, dummy 0x00
    snap();
    data_read = 8'h3C;
    send_byte(8'h4A);
    check("rd_strobe", read, 1);
    check("rd_state_cap", dbg_state, ST_READ_CAPTURE);
    check("rd_addr", addr, 6'h0A);
    check("rd_hl", hl_sel, 1);
    tick(1);
    check("rd_strobe_end", read, 0);
    check("rd_state_wait", dbg_state, ST_WAIT_DATA);
    check("rd_dout", data_out, 8'h3C);
    send_byte(8'h00);
    check("rd_state_idle", dbg_state, ST_IDLE);
    check("rd_dout_hold", data_out, 8'h3C);
    check("rd_dw_hold", data_write, 8'hA5);
    tick(1);
    check("rd_nrd", rd_cnt - rd0, 1);
    check("rd_nwr", wr_cnt - wr0, 0);

    // back-to-back: 0xC1,0x11 then immediately 0x01,0xFF
    snap();
    data_read = 8'h5A;
    send_byte(8'hC1);
    check("b2b_addr1", addr, 6'h01);
    check("b2b_hl1", hl_sel, 1);
    send_byte(8'h11);
    check("b2b_wr", write, 1);
    check("b2b_dw", data_write, 8'h11);
    send_byte(8'h01);
    check("b2b_rd", read, 1);
    check("b2b_addr2", addr, 6'h01);
    check("b2b_hl2", hl_sel, 0);
    tick(1);
    send_byte(8'hFF);
    check("b2b_idle", dbg_state, ST_IDLE);
    check("b2b_dout", data_out, 8'h5A);
    tick(1);
    check("b2b_nwr", wr_cnt - wr0, 1);
    check("b2b_nrd", rd_cnt - rd0, 1);

    // reset mid-transaction: 0x83, reset, then 0x22
    snap();
    send_byte(8'h83);
    check("mr_wait", dbg_state, ST_WAIT_DATA);
    rst_n = 1'b0;
    tick(1);
    check("mr_rst_state", dbg_state, ST_IDLE);
    check("mr_rst_addr", addr, 0);
    rst_n = 1'b1;
    tick(1);
    send_byte(8'h22);
    check("mr_rd", read, 1);
    check("mr_addr", addr, 6'h22);
    check("mr_hl", hl_sel, 0);
    tick(1);
    send_byte(8'h00);
    tick(1);
    check("mr_nwr", wr_cnt - wr0, 0);
    check("mr_nrd", rd_cnt - rd0, 1);

`ifdef INSTR_DECODER_TIMEOUT_EN
    // 0x90 then 16 idle cycles -> one timeout pulse, no write
    snap();
    send_byte(8'h90);
    tick(15);
    check("to_pre_state", dbg_state, ST_WAIT_DATA);
    check("to_pre_pulse", timeout, 0);
    tick(1);
    check("to_pulse", timeout, 1);
    check("to_state", dbg_state, ST_IDLE);
    tick(1);
    check("to_pulse_end", timeout, 0);
    send_byte(8'h45);
    check("to_next_rd", read, 1);
    check("to_next_addr", addr, 6'h05);
    tick(1);
    send_byte(8'h00);
    tick(1);
    check("to_ntimeout", to_cnt - to0, 1);
    check("to_nwr", wr_cnt - wr0, 0);

    // byte in the expiry cycle is accepted
    snap();
    send_byte(8'h90);
    tick(15);
    send_byte(8'h33);
    check("to_edge_wr", write, 1);
    check("to_edge_dw", data_write, 8'h33);
    check("to_edge_pulse", timeout, 0);
    tick(2);
    check("to_edge_nto", to_cnt - to0, 0);
`else
    // no timeout: data byte accepted after a long gap
    snap();
    send_byte(8'h90);
    tick(40);
    check("nto_wait", dbg_state, ST_WAIT_DATA);
    send_byte(8'h77);
    check("nto_wr", write, 1);
    check("nto_dw", data_write, 8'h77);
    check("nto_addr", addr, 6'h10);
    tick(1);
    check("nto_ntimeout", to_cnt - to0, 0);
`endif

    check("rw_overlap", ovl_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
